// File: rtl/fir_seq_ctrl_if.sv
// Bus bundle between fir_seq_ctrl and its surroundings.
//   Host:       start (in), busy/done/error (out)
//   Upstream:   in_valid/in_data (in), in_ready (out)
//   Downstream: out_valid/out_data (out), out_ready (in)
//   Filter:     f_reset/f_op/f_addr/f_x (out), f_y/f_done (in)
// The master modport is the controller's view; slave is the environment's view.
interface fir_seq_ctrl_if;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic        error;
   logic        f_reset;
   logic [1:0]  f_op;
   logic [31:0] f_addr;
   logic [31:0] f_x;
   logic [31:0] f_y;
   logic        f_done;

   modport master (
      input  start, in_valid, in_data, out_ready, f_y, f_done,
      output in_ready, out_valid, out_data, busy, done, error,
             f_reset, f_op, f_addr, f_x
   );

   modport slave (
      output start, in_valid, in_data, out_ready, f_y, f_done,
      input  in_ready, out_valid, out_data, busy, done, error,
             f_reset, f_op, f_addr, f_x
   );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequencer owning the op/address bus of one FIR filter: clears the filter, streams
// SIGNAL_LEN samples in, triggers compute (with a watchdog), then streams SIGNAL_LEN
// results out, one per RD_ISSUE/RD_CAP/RD_OUT round.
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   bus_io - fir_seq_ctrl_if.master (host, upstream, downstream and filter signals)
module fir_seq_ctrl #(
   parameter int unsigned SIGNAL_LEN     = 1000,
   parameter int unsigned MAX_RUN_CYCLES = 202000
) (
   input logic            clk,
   input logic            reset,
   fir_seq_ctrl_if.master bus_io
);

   localparam logic [31:0] LastIdx  = 32'(SIGNAL_LEN - 1);
   localparam logic [31:0] WdogLast = 32'(MAX_RUN_CYCLES - 1);

   typedef enum logic [3:0] {
      StIdle, StClear, StLoad, StRun, StRdIssue, StRdCap, StRdOut, StFin, StErr
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] wdog_q, wdog_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        done_q, done_d;
   logic        error_q, error_d;

   logic [1:0]  f_op;
   logic [31:0] f_addr;
   logic [31:0] f_x;
   logic        in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         wdog_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wdog_q      <= wdog_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wdog_d      = wdog_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      error_d     = error_q;
      f_op        = 2'b00;
      f_addr      = '0;
      f_x         = '0;
      in_ready    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus_io.start) state_d = StClear;
         end
         StClear: begin
            cnt_d   = '0;
            state_d = StLoad;
         end
         StLoad: begin
            in_ready = 1'b1;
            if (bus_io.in_valid) begin
               f_op   = 2'b01;
               f_addr = cnt_q;
               f_x    = bus_io.in_data;
               if (cnt_q == LastIdx) begin
                  cnt_d   = '0;
                  wdog_d  = '0;
                  state_d = StRun;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
         end
         StRun: begin
            f_op   = 2'b10;
            wdog_d = wdog_q + 32'd1;
            // Completion wins over a watchdog expiry in the same cycle.
            if (bus_io.f_done) begin
               cnt_d   = '0;
               state_d = StRdIssue;
            end else if (wdog_q == WdogLast) begin
               error_d = 1'b1;
               state_d = StErr;
            end
         end
         StRdIssue: begin
            f_op    = 2'b11;
            f_addr  = cnt_q;
            state_d = StRdCap;
         end
         StRdCap: begin
            // f_y is the registered answer to the read issued last cycle.
            out_data_d  = bus_io.f_y;
            out_valid_d = 1'b1;
            state_d     = StRdOut;
         end
         StRdOut: begin
            if (bus_io.out_ready) begin
               out_valid_d = 1'b0;
               if (cnt_q == LastIdx) begin
                  cnt_d   = '0;
                  state_d = StFin;
               end else begin
                  cnt_d   = cnt_q + 32'd1;
                  state_d = StRdIssue;
               end
            end
         end
         StFin: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         StErr: begin
            if (bus_io.start) begin
               error_d = 1'b0;
               state_d = StClear;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus_io.f_reset   = reset | (state_q == StClear);
   assign bus_io.f_op      = f_op;
   assign bus_io.f_addr    = f_addr;
   assign bus_io.f_x       = f_x;
   assign bus_io.in_ready  = in_ready;
   assign bus_io.busy      = !(state_q inside {StIdle, StErr});
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_data  = out_data_q;
   assign bus_io.done      = done_q;
   assign bus_io.error     = error_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl with SIGNAL_LEN=4, MAX_RUN_CYCLES=10 and a behavioural
// 2-tap filter (y[n] = x[n] + 2*x[n-1]) hanging off the filter bus.
module tb_fir_seq_ctrl;
   localparam int unsigned SigLen = 4;
   localparam int unsigned MaxRun = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fir_seq_ctrl_if bus ();

   fir_seq_ctrl #(
      .SIGNAL_LEN    (SigLen),
      .MAX_RUN_CYCLES(MaxRun)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus_io(bus)
   );

   int checks = 0;
   int failures = 0;

   // Filter model and bus observers.
   logic [31:0] fmem [SigLen];
   int          comp_cnt = 0;
   int          lat = 1;
   bit          hang = 1'b0;
   int          writes = 0, reads = 0, addr_bad = 0, wr_bad = 0, rd_stall = 0;
   int          done_cnt = 0, done_long = 0;
   logic        done_prev = 1'b0;
   logic [31:0] waddr_q [$];
   logic [31:0] raddr_q [$];

   function automatic logic [31:0] conv_at(logic [1:0] a);
      logic [31:0] r;
      r = fmem[a];
      if (a != 2'd0) r = r + 32'd2 * fmem[a - 2'd1];
      return r;
   endfunction

   always @(posedge clk) begin
      done_prev <= bus.done;
      if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
      if (bus.done === 1'b1 && done_prev === 1'b1) done_long <= done_long + 1;
      if (bus.f_reset !== 1'b0) begin
         comp_cnt    <= 0;
         bus.f_done  <= 1'b0;
         bus.f_y     <= '0;
         for (int i = 0; i < SigLen; i++) fmem[i] <= '0;
      end else begin
         case (bus.f_op)
            2'b01: begin
               writes <= writes + 1;
               waddr_q.push_back(bus.f_addr);
               if (bus.in_valid !== 1'b1) wr_bad <= wr_bad + 1;
               if (bus.f_addr < SigLen) fmem[bus.f_addr[1:0]] <= bus.f_x;
               else addr_bad <= addr_bad + 1;
            end
            2'b10: begin
               comp_cnt <= comp_cnt + 1;
               if (!hang && comp_cnt + 1 >= lat) bus.f_done <= 1'b1;
            end
            2'b11: begin
               reads <= reads + 1;
               raddr_q.push_back(bus.f_addr);
               if (bus.out_valid === 1'b1) rd_stall <= rd_stall + 1;
               if (bus.f_addr < SigLen) bus.f_y <= conv_at(bus.f_addr[1:0]);
               else addr_bad <= addr_bad + 1;
            end
            default: ;
         endcase
      end
   end

   // Per-block stimulus settings.
   logic [31:0] xin [SigLen];
   int          gap_a [SigLen];
   int          stall_idx = -1;
   int          stall_len = 0;
   bit          poke = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Call from IDLE or ERR; returns with the controller in LOAD.
   task automatic start_block();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      #1;
      chk("clr_f_reset", bus.f_reset, 1);
      chk("clr_busy", bus.busy, 1);
      chk("clr_error", bus.error, 0);
      tick();
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < gap_a[i]; g++) begin
            bus.in_valid = 1'b0;
            #1;
            chk("gap_f_op", bus.f_op, 2'b00);
            chk("gap_in_ready", bus.in_ready, 1);
            tick();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = xin[i];
         #1;
         chk("ld_in_ready", bus.in_ready, 1);
         chk("ld_f_op", bus.f_op, 2'b01);
         chk("ld_f_addr", bus.f_addr, 32'(i));
         chk("ld_f_x", bus.f_x, xin[i]);
         tick();
      end
      bus.in_valid = 1'b0;
      #1;
      if (n == SigLen) begin
         chk("run_entered", bus.f_op, 2'b10);
         chk("run_in_ready", bus.in_ready, 0);
      end
   endtask

   task automatic run_block();
      int          wr0, rd0, dn0, n;
      logic [31:0] exp;
      wr0 = writes;
      rd0 = reads;
      dn0 = done_cnt;
      start_block();
      feed(SigLen);
      n = 0;
      while (bus.f_op == 2'b10 && n < 20) begin
         if (poke) begin
            bus.start    = 1'b1;
            bus.in_valid = 1'b1;
            #1;
            chk("run_poke_in_ready", bus.in_ready, 0);
         end
         tick();
         bus.start    = 1'b0;
         bus.in_valid = 1'b0;
         #1;
         n++;
      end
      chk("run_exit_rd_issue", bus.f_op, 2'b11);
      chk("run_no_error", bus.error, 0);
      for (int i = 0; i < SigLen; i++) begin
         exp = xin[i];
         if (i > 0) exp = exp + 32'd2 * xin[i-1];
         n = 0;
         while (bus.out_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
         end
         chk("out_valid", bus.out_valid, 1);
         if (i == stall_idx) begin
            for (int s = 0; s < stall_len; s++) begin
               if (poke) bus.start = 1'b1;
               #1;
               chk("stall_valid", bus.out_valid, 1);
               chk("stall_data", bus.out_data, exp);
               tick();
               bus.start = 1'b0;
            end
         end
         bus.out_ready = 1'b1;
         #1;
         chk("out_data", bus.out_data, exp);
         tick();
         bus.out_ready = 1'b0;
         #1;
         chk("out_valid_drop", bus.out_valid, 0);
      end
      chk("fin_busy", bus.busy, 1);
      chk("fin_done_low", bus.done, 0);
      tick();
      chk("done_pulse", bus.done, 1);
      chk("done_busy_low", bus.busy, 0);
      chk("done_f_op", bus.f_op, 2'b00);
      tick();
      chk("done_one_cycle", bus.done, 0);
      chk("blk_writes", 32'(writes - wr0), SigLen);
      chk("blk_reads", 32'(reads - rd0), SigLen);
      chk("blk_done_cnt", 32'(done_cnt - dn0), 1);
      for (int i = 0; i < SigLen; i++) begin
         chk("blk_waddr", waddr_q[wr0 + i], 32'(i));
         chk("blk_raddr", raddr_q[rd0 + i], 32'(i));
      end
   endtask

   task automatic set_seq(input logic [31:0] base);
      for (int i = 0; i < SigLen; i++) begin
         xin[i]   = base + 32'(i);
         gap_a[i] = 0;
      end
   endtask

   initial begin
      int dn0;
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_f_reset_hi", bus.f_reset, 1);
      reset = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_error", bus.error, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_f_op", bus.f_op, 2'b00);
      chk("rst_f_addr", bus.f_addr, 0);
      chk("rst_f_x", bus.f_x, 0);
      chk("rst_f_reset_lo", bus.f_reset, 0);
      tick();

      // Basic block: 1,2,3,4 -> 1,4,7,10.
      set_seq(32'd1);
      lat = 3;
      run_block();

      // Backpressure on the second result.
      stall_idx = 1;
      stall_len = 5;
      run_block();
      stall_idx = -1;
      stall_len = 0;

      // Bursty input: in_valid 1,0,0,1,1,0,1.
      gap_a[1] = 2;
      gap_a[3] = 1;
      run_block();

      // Completion seen on the last watchdog cycle: completion wins.
      set_seq(32'd20);
      lat = 9;
      run_block();

      // Watchdog expiry, then full restart from ERR.
      hang = 1'b1;
      dn0  = done_cnt;
      start_block();
      feed(SigLen);
      for (int k = 0; k < MaxRun; k++) begin
         chk("wd_run_f_op", bus.f_op, 2'b10);
         tick();
      end
      chk("wd_error", bus.error, 1);
      chk("wd_busy", bus.busy, 0);
      chk("wd_f_op", bus.f_op, 2'b00);
      tick();
      chk("wd_error_sticky", bus.error, 1);
      chk("wd_no_done", 32'(done_cnt - dn0), 0);
      hang = 1'b0;
      lat  = 4;
      set_seq(32'd100);
      run_block();

      // Reset in the middle of LOAD after two samples.
      set_seq(32'd5);
      start_block();
      feed(2);
      dn0   = done_cnt;
      reset = 1'b1;
      #1;
      chk("mid_rst_f_reset", bus.f_reset, 1);
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_in_ready", bus.in_ready, 0);
      chk("mid_rst_f_op", bus.f_op, 2'b00);
      tick();
      tick();
      chk("mid_rst_no_done", 32'(done_cnt - dn0), 0);
      set_seq(32'd40);
      run_block();

      // start/in_valid pokes during RUN and RD_OUT.
      poke      = 1'b1;
      stall_idx = 2;
      stall_len = 3;
      run_block();

      // Randomized blocks.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < SigLen; i++) begin
            xin[i]   = $urandom;
            gap_a[i] = int'($urandom_range(0, 2));
         end
         lat       = int'($urandom_range(1, 6));
         stall_idx = int'($urandom_range(0, SigLen - 1));
         stall_len = int'($urandom_range(0, 3));
         poke      = 1'($urandom_range(0, 1));
         run_block();
      end

      chk("addr_in_range", 32'(addr_bad), 0);
      chk("no_write_without_valid", 32'(wr_bad), 0);
      chk("no_read_while_valid", 32'(rd_stall), 0);
      chk("done_never_long", 32'(done_long), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Sequencer that owns the operation/address bus of one FIR filter instance. It resets the filter, streams a block of SIGNAL_LEN input samples into it, triggers the convolution, waits for completion, then streams the SIGNAL_LEN results out.
- Upstream and downstream sides are valid/ready streams.
- The host only issues start and watches done/error.

Parameters:
SIGNAL_LEN, 1000, samples per block; must match the filter's signal length.
MAX_RUN_CYCLES, 202000, watchdog limit on cycles spent waiting for filter done.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin one block (sampled only in IDLE/ERR)
in_valid  in  1  input sample valid
in_data  in  32  input sample
in_ready  out  1  controller accepts in_data this cycle
out_valid  out  1  result valid
out_data  out  32  result sample
out_ready  in  1  downstream accepts result
busy  out  1  high in every state except IDLE/ERR
done  out  1  one-cycle pulse, block finished
error  out  1  sticky watchdog flag
f_reset  out  1  filter reset
f_op  out  2  filter operation: 00 idle, 01 write, 10 compute, 11 read
f_addr  out  32  filter sample/result index
f_x  out  32  filter write data
f_y  in  32  filter read data; registered, valid one cycle after f_op=11
f_done  in  1  filter compute complete

Behaviour:
- Reset: state=IDLE, cnt=0, wdog=0. Outputs: out_valid=0, out_data=0, done=0, error=0, busy=0, in_ready=0, f_op=00, f_addr=0, f_x=0.
- f_reset = reset OR (state==CLEAR).
- f_op/f_addr/f_x/in_ready are combinational from state and counters. out_data, out_valid, done and error are registered.
- IDLE: f_op=00. start=1 -> CLEAR.
- CLEAR: one cycle with f_reset=1; cnt<=0 -> LOAD.
- LOAD:
  - in_ready=1.
  - When in_valid=1: f_op=01, f_addr=cnt, f_x=in_data, cnt<=cnt+1. Otherwise f_op=00.
  - Accepting the sample with cnt==SIGNAL_LEN-1 -> RUN, with cnt<=0 and wdog<=0.
  - One sample per cycle maximum; gaps in in_valid are allowed.
- RUN:
  - f_op=10 held every cycle; wdog increments.
  - f_done=1 -> RD_ISSUE (cnt=0).
  - Otherwise, wdog==MAX_RUN_CYCLES-1 -> ERR.
  - f_done has priority over the watchdog in the same cycle.
- RD_ISSUE: f_op=11, f_addr=cnt -> RD_CAP.
- RD_CAP: f_op=00; out_data<=f_y, out_valid<=1 -> RD_OUT.
- RD_OUT:
  - out_valid=1; out_data stable until out_ready=1.
  - On the handshake, out_valid<=0. If cnt==SIGNAL_LEN-1 -> FIN, else cnt<=cnt+1 -> RD_ISSUE.
  - Throughput is at most one result per 3 cycles.
- FIN: done<=1 for exactly one cycle -> IDLE; busy falls in the same cycle done is high.
- ERR:
  - f_op=00, error=1 (sticky), busy=0.
  - start=1 -> clears error and goes to CLEAR (full restart).
- start while busy: ignored, no restart.
- in_valid outside LOAD: ignored; in_ready=0, no filter write.
- out_ready without out_valid: no effect.
- Reset mid-block (any state): IDLE next cycle; the filter is cleared by f_reset; partially loaded or partially read data is discarded; no done pulse.
- Counters are 32 bits. cnt never exceeds SIGNAL_LEN-1; the filter never sees an out-of-range address.

Test Plan:
1. SIGNAL_LEN=4 with a behavioural filter model (coefs [1,2]). start, feed 1,2,3,4 back-to-back -> f_op=01 writes at f_addr 0..3, then f_op=10 until f_done. Outputs 1,4,7,10 in order, then done pulse 1 cycle; total writes=4, reads=4.
2. Backpressure: hold out_ready=0 for 5 cycles on the 2nd result -> out_valid stays 1 and out_data=4 stable. No new f_op=11 is issued until the handshake. Sequence completes unchanged.
3. Bursty input: in_valid toggles 1,0,0,1,1,0,1 -> exactly 4 writes at addresses 0..3, with f_op=00 in gap cycles. RUN is entered the cycle after the 4th accept.
4. Watchdog: MAX_RUN_CYCLES=10, model never raises f_done -> after 10 RUN cycles error=1, busy=0, f_op=00. start -> error clears, f_reset pulses, block runs normally.
5. Reset mid-LOAD after 2 samples -> next cycle IDLE, f_reset=1 during reset, no done. A new start loads from address 0.
6. start asserted during RUN and RD_OUT -> ignored; done pulses exactly once per block; in_valid during RUN leaves in_ready=0.
